ps_int_ctrl: RTL and testbench

Interrupt controller for the program sequencer. It latches external interrupt events, applies the IMASK and global-enable gating, and picks the highest-priority eligible source. It then runs a request/acknowledge handshake with the sequencer to vector it to a fixed address, and tracks in-service (nesting) state until the matching return-from-interrupt. It also drives the level wake-up that releases the sequencer from IDLE.

---
 rtl/ps_int_ctrl_if.sv | 40 ++++
 rtl/ps_int_ctrl.sv | 137 +++++++++++++
 tb/tb_ps_int_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps_int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ps_int_ctrl_if
// Description : Sequencer <-> interrupt controller handshake and register bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps_int_ctrl_if #(
    parameter int NUM_IRQ = 4
);
    logic               ps_ic_gie;
    logic               ps_ic_stall;
    logic               ps_ic_imask_we;
    logic [NUM_IRQ-1:0] ps_ic_imask_wdt;
    logic               ps_ic_vec_ack;
    logic               ps_ic_rti;

    logic               ic_ps_vec_req;
    logic [15:0]        ic_ps_vec_add;
    logic [NUM_IRQ-1:0] ic_ps_irptl;
    logic [NUM_IRQ-1:0] ic_ps_imask;
    logic [NUM_IRQ-1:0] ic_ps_imaskp;
    logic               ic_ps_wake;

    // Sequencer side
    modport master (
        output ps_ic_gie, ps_ic_stall, ps_ic_imask_we, ps_ic_imask_wdt,
               ps_ic_vec_ack, ps_ic_rti,
        input  ic_ps_vec_req, ic_ps_vec_add, ic_ps_irptl, ic_ps_imask,
               ic_ps_imaskp, ic_ps_wake
    );

    // Interrupt controller side
    modport slave (
        input  ps_ic_gie, ps_ic_stall, ps_ic_imask_we, ps_ic_imask_wdt,
               ps_ic_vec_ack, ps_ic_rti,
        output ic_ps_vec_req, ic_ps_vec_add, ic_ps_irptl, ic_ps_imask,
               ic_ps_imaskp, ic_ps_wake
    );
endinterface
`default_nettype wire

// File: rtl/ps_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps_int_ctrl
// Description : Edge-latched, masked, priority interrupt controller with
//               vector request/ack handshake and nesting (in-service) tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module ps_int_ctrl #(
    parameter int          NUM_IRQ   = 4,
    parameter logic [15:0] VEC_BASE  = 16'h0040,
    parameter int          VEC_SHIFT = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [NUM_IRQ-1:0] irq_in,
    ps_int_ctrl_if.slave            bus
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_irq_d;
    logic [NUM_IRQ-1:0] r_irptl;
    logic [NUM_IRQ-1:0] r_imask;
    logic [NUM_IRQ-1:0] r_imaskp;
    logic [IDX_W-1:0]   r_win_idx;
    logic               r_vec_req;
    logic [15:0]        r_vec_add;
    logic               r_wake;

    logic [NUM_IRQ-1:0] w_event;
    logic [NUM_IRQ-1:0] w_blk;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_ack_oh;
    logic [NUM_IRQ-1:0] w_rti_clr;
    logic [NUM_IRQ-1:0] w_irptl_nxt;
    logic [NUM_IRQ-1:0] w_imaskp_nxt;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_any;
    logic               w_ack;
    logic [15:0]        w_vec_add;

    assign w_event = irq_in & ~r_irq_d;
    assign w_ack   = (r_state == ST_REQ) && bus.ps_ic_vec_ack;

    // A source is blocked while it or any higher-priority source is in service
    always_comb begin
        logic acc;
        acc   = 1'b0;
        w_blk = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            acc      = acc | r_imaskp[i];
            w_blk[i] = acc;
        end
    end

    assign w_elig = r_irptl & r_imask & ~w_blk;
    assign w_any  = |w_elig;

    always_comb begin
        w_win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_ack_oh = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_ack_oh[i] = w_ack && (r_win_idx == IDX_W'(i));
        end
    end

    assign w_vec_add = VEC_BASE + (16'(w_win_idx) << VEC_SHIFT);

    // Lowest set in-service bit; RTI on an empty IMASKP yields an all-zero mask
    assign w_rti_clr    = {NUM_IRQ{bus.ps_ic_rti}} & r_imaskp & ~(r_imaskp - NUM_IRQ'(1));
    assign w_irptl_nxt  = (r_irptl & ~w_ack_oh) | w_event;
    assign w_imaskp_nxt = (r_imaskp & ~w_rti_clr) | w_ack_oh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_irq_d   <= '0;
            r_irptl   <= '0;
            r_imask   <= '0;
            r_imaskp  <= '0;
            r_win_idx <= '0;
            r_vec_req <= 1'b0;
            r_vec_add <= 16'h0000;
            r_wake    <= 1'b0;
        end else begin
            r_irq_d  <= irq_in;
            r_irptl  <= w_irptl_nxt;
            r_imaskp <= w_imaskp_nxt;
            r_wake   <= |(r_irptl & r_imask);
            if (bus.ps_ic_imask_we) begin
                r_imask <= bus.ps_ic_imask_wdt;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any && bus.ps_ic_gie && !bus.ps_ic_stall) begin
                        r_state   <= ST_REQ;
                        r_win_idx <= w_win_idx;
                        r_vec_req <= 1'b1;
                        r_vec_add <= w_vec_add;
                    end
                end
                ST_REQ: begin
                    // Committed request is held regardless of mask/GIE/stall
                    if (bus.ps_ic_vec_ack) begin
                        r_state   <= ST_IDLE;
                        r_vec_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_vec_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ic_ps_vec_req = r_vec_req;
    assign bus.ic_ps_vec_add = r_vec_add;
    assign bus.ic_ps_irptl   = r_irptl;
    assign bus.ic_ps_imask   = r_imask;
    assign bus.ic_ps_imaskp  = r_imaskp;
    assign bus.ic_ps_wake    = r_wake;
endmodule
`default_nettype wire

// File: tb/tb_ps_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps_int_ctrl
// Description : Directed scenarios plus randomized traffic against a
//               behavioural model of the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps_int_ctrl;
    localparam int          N         = 4;
    localparam logic [15:0] VEC_BASE  = 16'h0040;
    localparam int          VEC_SHIFT = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq;
    int           n_chk;
    int           n_pass;

    ps_int_ctrl_if #(.NUM_IRQ(N)) bus ();

    ps_int_ctrl #(
        .NUM_IRQ   (N),
        .VEC_BASE  (VEC_BASE),
        .VEC_SHIFT (VEC_SHIFT)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state
    bit          m_irqd [N];
    bit          m_pend [N];
    bit          m_mask [N];
    bit          m_isr  [N];
    bit          m_req;
    int          m_idx;
    logic [15:0] m_add;
    bit          m_wake;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [N-1:0] pack(input bit a [N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    // Advance the model by one clock using the inputs present at this edge
    task automatic model_step();
        int hp, win;
        bit ev, ack_now, wk;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_irqd[i] = 0; m_pend[i] = 0; m_mask[i] = 0; m_isr[i] = 0;
            end
            m_req = 0; m_idx = 0; m_add = 16'h0000; m_wake = 0;
            return;
        end
        hp = N;
        for (int i = N - 1; i >= 0; i--) if (m_isr[i]) hp = i;
        win = -1;
        for (int i = hp - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
        wk = 0;
        for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) wk = 1;
        ack_now = m_req && bus.ps_ic_vec_ack;
        for (int i = 0; i < N; i++) begin
            ev = irq[i] && !m_irqd[i];
            if (ack_now && i == m_idx) m_pend[i] = ev;
            else                       m_pend[i] = m_pend[i] || ev;
        end
        if (bus.ps_ic_rti) begin
            for (int i = 0; i < N; i++) begin
                if (m_isr[i]) begin m_isr[i] = 0; break; end
            end
        end
        if (ack_now) m_isr[m_idx] = 1;
        if (m_req) begin
            if (bus.ps_ic_vec_ack) m_req = 0;
        end else if (win >= 0 && bus.ps_ic_gie && !bus.ps_ic_stall) begin
            m_req = 1;
            m_idx = win;
            m_add = 16'((int'(VEC_BASE) + win * (2 ** VEC_SHIFT)) % 65536);
        end
        m_wake = wk;
        if (bus.ps_ic_imask_we)
            for (int i = 0; i < N; i++) m_mask[i] = bus.ps_ic_imask_wdt[i];
        for (int i = 0; i < N; i++) m_irqd[i] = irq[i];
    endtask

    task automatic compare_all();
        chk("req", 32'(bus.ic_ps_vec_req), 32'(m_req));
        if (m_req) chk("add", 32'(bus.ic_ps_vec_add), 32'(m_add));
        chk("irptl", 32'(bus.ic_ps_irptl), 32'(pack(m_pend)));
        chk("imask", 32'(bus.ic_ps_imask), 32'(pack(m_mask)));
        chk("imaskp", 32'(bus.ic_ps_imaskp), 32'(pack(m_isr)));
        chk("wake", 32'(bus.ic_ps_wake), 32'(m_wake));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!bus.ic_ps_vec_req && n < budget) begin
            tick();
            n++;
        end
        chk("wait_req", 32'(bus.ic_ps_vec_req), 32'd1);
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        bus.ps_ic_imask_we = 1'b1; bus.ps_ic_imask_wdt = v;
        tick();
        bus.ps_ic_imask_we = 1'b0;
    endtask

    task automatic pulse_irq(input logic [N-1:0] v);
        irq = v; tick();
        irq = '0; tick();
    endtask

    task automatic do_ack();
        bus.ps_ic_vec_ack = 1'b1; tick(); bus.ps_ic_vec_ack = 1'b0;
    endtask

    task automatic do_rti();
        bus.ps_ic_rti = 1'b1; tick(); bus.ps_ic_rti = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; irq = '0;
        bus.ps_ic_gie = 1'b0; bus.ps_ic_stall = 1'b0; bus.ps_ic_imask_we = 1'b0;
        bus.ps_ic_imask_wdt = '0; bus.ps_ic_vec_ack = 1'b0; bus.ps_ic_rti = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_add", 32'(bus.ic_ps_vec_add), 32'h0);
        chk("rst_req", 32'(bus.ic_ps_vec_req), 32'h0);

        // Basic vector
        write_mask(4'b0100);
        bus.ps_ic_gie = 1'b1;
        irq = 4'b0100; tick();
        chk("basic_early_req", 32'(bus.ic_ps_vec_req), 32'h0);
        irq = '0; tick();
        chk("basic_req", 32'(bus.ic_ps_vec_req), 32'h1);
        chk("basic_add", 32'(bus.ic_ps_vec_add), 32'h0048);
        do_ack();
        chk("basic_irptl", 32'(bus.ic_ps_irptl), 32'h0);
        chk("basic_isr", 32'(bus.ic_ps_imaskp), 32'h4);
        do_rti();
        chk("basic_rti", 32'(bus.ic_ps_imaskp), 32'h0);

        // Priority and nesting
        write_mask(4'b1110);
        pulse_irq(4'b0100); wait_req(4); do_ack();
        pulse_irq(4'b1010);
        chk("nest_add", 32'(bus.ic_ps_vec_add), 32'h0044);
        chk("nest_pend", 32'(bus.ic_ps_irptl), 32'hA);
        do_ack();
        chk("nest_isr", 32'(bus.ic_ps_imaskp), 32'h6);
        do_rti(); do_rti();
        wait_req(4);
        chk("nest_src3", 32'(bus.ic_ps_vec_add), 32'h004C);
        do_ack(); do_rti();

        // Gating by IMASK, then by GIE
        write_mask(4'b0000);
        pulse_irq(4'b0001);
        chk("gate_irptl", 32'(bus.ic_ps_irptl), 32'h1);
        chk("gate_wake", 32'(bus.ic_ps_wake), 32'h0);
        write_mask(4'b0001);
        tick();
        chk("gate_wake_on", 32'(bus.ic_ps_wake), 32'h1);
        chk("gate_add", 32'(bus.ic_ps_vec_add), 32'h0040);
        do_ack(); do_rti();
        write_mask(4'b0000);
        bus.ps_ic_gie = 1'b0;
        pulse_irq(4'b0001);
        write_mask(4'b0001);
        tick();
        chk("gie_wake", 32'(bus.ic_ps_wake), 32'h1);
        chk("gie_noreq", 32'(bus.ic_ps_vec_req), 32'h0);

        // Stall, then commitment of a request
        bus.ps_ic_gie = 1'b1; bus.ps_ic_stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_noreq", 32'(bus.ic_ps_vec_req), 32'h0);
        bus.ps_ic_stall = 1'b0; tick();
        chk("stall_rel", 32'(bus.ic_ps_vec_req), 32'h1);
        bus.ps_ic_imask_we = 1'b1; bus.ps_ic_imask_wdt = '0; bus.ps_ic_gie = 1'b0;
        tick(); bus.ps_ic_imask_we = 1'b0; tick(); tick();
        chk("commit_req", 32'(bus.ic_ps_vec_req), 32'h1);
        chk("commit_add", 32'(bus.ic_ps_vec_add), 32'h0040);
        do_ack(); do_rti();

        // Event on the winner in the same cycle as its ack
        write_mask(4'b0100);
        bus.ps_ic_gie = 1'b1;
        pulse_irq(4'b0100); wait_req(4);
        irq = 4'b0100; bus.ps_ic_vec_ack = 1'b1; tick();
        irq = '0; bus.ps_ic_vec_ack = 1'b0;
        chk("sim_irptl", 32'(bus.ic_ps_irptl), 32'h4);
        tick(); tick();
        chk("sim_blocked", 32'(bus.ic_ps_vec_req), 32'h0);
        do_rti(); tick();
        chk("sim_rereq", 32'(bus.ic_ps_vec_req), 32'h1);
        chk("sim_add", 32'(bus.ic_ps_vec_add), 32'h0048);
        do_ack(); do_rti();

        // Reset while a request is outstanding
        pulse_irq(4'b0100); wait_req(4);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstreq_req", 32'(bus.ic_ps_vec_req), 32'h0);
        chk("rstreq_add", 32'(bus.ic_ps_vec_add), 32'h0);
        chk("rstreq_mask", 32'(bus.ic_ps_imask), 32'h0);
        do_ack();
        chk("late_ack_isr", 32'(bus.ic_ps_imaskp), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst                 = ($urandom_range(0, 299) == 0);
            irq                 = N'($urandom);
            bus.ps_ic_gie       = ($urandom_range(0, 7) != 0);
            bus.ps_ic_stall     = ($urandom_range(0, 3) == 0);
            bus.ps_ic_imask_we  = ($urandom_range(0, 15) == 0);
            bus.ps_ic_imask_wdt = N'($urandom);
            bus.ps_ic_vec_ack   = ($urandom_range(0, 2) == 0);
            bus.ps_ic_rti       = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
